mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter_reg.sv | 20 ++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, completion error code, grant owner
// and the rv32i default widths.
package mem_arb_pkg;

    localparam int unsigned RV32I_XLEN       = 32;
    localparam int unsigned RV32I_ADDR_WIDTH = RV32I_XLEN;
    localparam int unsigned RV32I_WORD_WIDTH = RV32I_XLEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        ERR_NONE    = 1'b0,
        ERR_TIMEOUT = 1'b1
    } arb_err_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_reg.sv
// Enable-loaded register with asynchronous active-low clear; holds the granted request fields.
module mem_arbiter_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store ports onto a single request/response
// memory interface, with anti-starvation for fetches and a per-transaction timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = RV32I_ADDR_WIDTH,
    parameter int unsigned WORD_WIDTH     = RV32I_WORD_WIDTH,
    parameter int unsigned D_BURST_MAX    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [WORD_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic                  d_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  stall_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    localparam logic [7:0]  DCNT_MAX  = 8'(D_BURST_MAX);
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        arb_owner_e            owner;
        logic                  we;
        logic                  mode;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] wdata;
    } req_t;

    arb_state_e            state_q, state_d;
    arb_err_e              err_q, err_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [15:0]           tcnt_q, tcnt_d;
    logic [WORD_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [WORD_WIDTH-1:0] resp_data;
    logic                  resp_load;
    logic                  lat_en;
    req_t                  lat_d, lat_q;
    logic                  d_any, grant_i;

    assign d_any   = d_read | d_write;
    assign grant_i = i_req & (~d_any | (dcnt_q == DCNT_MAX));

    // d_write wins over d_read when both are raised, so a combined request is a store.
    always_comb begin
        lat_d = '0;
        if (grant_i) begin
            lat_d.owner = OWNER_I;
            lat_d.addr  = i_addr;
        end else begin
            lat_d.owner = OWNER_D;
            lat_d.we    = d_write;
            lat_d.mode  = d_mode;
            lat_d.addr  = d_addr;
            lat_d.wdata = d_wdata;
        end
    end

    mem_arbiter_reg #(
        .WIDTH($bits(req_t))
    ) u_req_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (lat_en),
        .d    (lat_d),
        .q    (lat_q)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        dcnt_d    = dcnt_q;
        tcnt_d    = tcnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        lat_en    = 1'b0;
        resp_load = 1'b0;
        resp_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_any) begin
                    lat_en  = 1'b1;
                    state_d = ST_ISSUE;
                    tcnt_d  = '0;
                    if (grant_i || !i_req) begin
                        dcnt_d = '0;
                    end else if (dcnt_q != DCNT_MAX) begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                tcnt_d = tcnt_q + 16'd1;
                // A genuine completion in the final counted cycle still beats the timeout.
                if (state_q == ST_WAIT && mem_rvalid) begin
                    state_d   = ST_RESP;
                    err_d     = ERR_NONE;
                    resp_load = 1'b1;
                    resp_data = mem_rdata;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d   = ST_RESP;
                    err_d     = ERR_TIMEOUT;
                    resp_load = 1'b1;
                end else if (state_q == ST_ISSUE && mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (resp_load) begin
            if (lat_q.owner == OWNER_I) begin
                i_rdata_d = resp_data;
            end else begin
                d_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            dcnt_q    <= '0;
            tcnt_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            dcnt_q    <= dcnt_d;
            tcnt_q    <= tcnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_done    = (state_q == ST_RESP) && (lat_q.owner == OWNER_I);
    assign d_done    = (state_q == ST_RESP) && (lat_q.owner == OWNER_D);
    assign err       = (state_q == ST_RESP) && (err_q == ERR_TIMEOUT);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_n   = ~((i_req & ~i_done) | (d_any & ~d_done));
    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_we    = lat_q.we;
    assign mem_mode  = lat_q.mode;
    assign mem_addr  = lat_q.addr;
    assign mem_wdata = lat_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; expected grants, data and timing come
// from a transaction-level model of the arbitration and timeout rules.
module tb_mem_arbiter;

    localparam int unsigned TMO   = 8;
    localparam int unsigned D_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic        d_mode;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        stall_n;
    logic        mem_req;
    logic        mem_we;
    logic        mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          n_cmp;
    int          n_bad;
    int unsigned dcnt_m;
    logic [31:0] last_i;
    logic [31:0] last_d;

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .WORD_WIDTH    (32),
        .D_BURST_MAX   (D_MAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_mode    (d_mode),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .err       (err),
        .stall_n   (stall_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_idone"}, i_done, 0);
        chk({tag, "_ddone"}, d_done, 0);
    endtask

    // One full transaction starting from an IDLE cycle with a request present.
    // r: cycles mem_ready is withheld, v: WAIT cycles before mem_rvalid, tmo: never answer.
    task automatic run_txn(input int unsigned r, input int unsigned v, input bit tmo,
                           input bit perturb, input logic [31:0] rd_val, output bit got_i);
        bit          gi;
        logic        exp_we;
        logic        exp_mode;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        logic        exp_err;

        gi = i_req && (!(d_read || d_write) || dcnt_m == D_MAX);
        if (gi)         dcnt_m = 0;
        else if (i_req) dcnt_m = (dcnt_m < D_MAX) ? dcnt_m + 1 : D_MAX;
        else            dcnt_m = 0;
        exp_we    = gi ? 1'b0 : d_write;
        exp_addr  = gi ? i_addr : d_addr;
        exp_wdata = d_wdata;
        exp_mode  = d_mode;

        step();
        chk("issue_req", mem_req, 1);
        chk("issue_we", mem_we, exp_we);
        chk("issue_addr", mem_addr, exp_addr);
        if (!gi) begin
            chk("issue_wdata", mem_wdata, exp_wdata);
            chk("issue_mode", mem_mode, exp_mode);
        end
        if (perturb) begin
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_mode  = 1'($urandom % 2);
            i_req   = i_req & 1'($urandom % 2);
            d_read  = d_read & 1'($urandom % 2);
            d_write = d_write & 1'($urandom % 2);
        end
        for (int unsigned k = 0; k < r; k++) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'($urandom % 2);
            mem_rdata  = $urandom;
            step();
            chk("hold_req", mem_req, 1);
            chk("hold_we", mem_we, exp_we);
            chk("hold_addr", mem_addr, exp_addr);
            if (!gi) chk("hold_wdata", mem_wdata, exp_wdata);
            chk_quiet("hold");
        end
        mem_ready  = 1'b1;
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("wait_req", mem_req, 0);
        chk_quiet("wait");
        if (!tmo) begin
            for (int unsigned k = 0; k < v; k++) begin
                step();
                chk("wait_req", mem_req, 0);
                chk_quiet("wait");
            end
            exp_rd     = rd_val;
            exp_err    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rd_val;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end else begin
            for (int unsigned k = r + 2; k < TMO; k++) begin
                step();
                chk_quiet("tmo_wait");
            end
            step();
            exp_rd  = '0;
            exp_err = 1'b1;
        end
        if (gi) last_i = exp_rd;
        else    last_d = exp_rd;
        got_i = i_done;
        chk("resp_idone", i_done, gi);
        chk("resp_ddone", d_done, !gi);
        chk("resp_err", err, exp_err);
        chk("resp_irdata", i_rdata, last_i);
        chk("resp_drdata", d_rdata, last_d);
        chk("resp_stall_n", stall_n, !((i_req && !gi) || ((d_read || d_write) && gi)));
        step();
        chk_quiet("post");
        chk("post_err", err, 0);
        chk("post_req", mem_req, 0);
        chk("post_irdata", i_rdata, last_i);
        chk("post_drdata", d_rdata, last_d);
        chk("post_stall_n", stall_n, !(i_req || d_read || d_write));
    endtask

    initial begin
        bit g;
        n_cmp      = 0;
        n_bad      = 0;
        dcnt_m     = 0;
        last_i     = '0;
        last_d     = '0;
        rst_n      = 1'b0;
        i_req      = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_mode     = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset values.
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        chk_quiet("rst");
        chk("rst_stall_n", stall_n, 1);
        i_req = 1'b1;
        #1;
        chk("rst_stall_n_req", stall_n, 0);
        i_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Single fetch with minimum latency.
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        run_txn(0, 0, 1'b0, 1'b0, 32'h0000_0013, g);
        chk("fetch_grant_i", g, 1);
        i_req = 1'b0;

        // Store held off by three cycles of mem_ready=0.
        d_write = 1'b1;
        d_mode  = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hDEAD_BEEF;
        run_txn(3, 0, 1'b0, 1'b0, 32'h1234_5678, g);
        chk("store_grant_d", g, 0);
        d_write = 1'b0;
        d_mode  = 1'b0;

        // Timeout followed by a normal load.
        d_read = 1'b1;
        d_addr = 32'h0000_0400;
        run_txn(0, 0, 1'b1, 1'b0, 32'h0, g);
        run_txn(0, 1, 1'b0, 1'b0, 32'hA5A5_0001, g);
        chk("after_tmo_grant_d", g, 0);

        // Sustained contention: D,D,D,D,I,D.
        i_req  = 1'b1;
        i_addr = 32'h0000_0800;
        d_addr = 32'h0000_0900;
        for (int n = 0; n < 6; n++) begin
            run_txn(0, 0, 1'b0, 1'b0, $urandom, g);
            chk("contention_order", g, (n == 4));
        end
        i_req  = 1'b0;
        d_read = 1'b0;

        // Reset while waiting for read data.
        i_req  = 1'b1;
        i_addr = 32'h0000_0300;
        step();
        chk("rmid_issue", mem_req, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("rmid_wait", mem_req, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_mem_req", mem_req, 0);
        chk("rmid_mem_addr", mem_addr, 0);
        chk("rmid_err", err, 0);
        chk("rmid_irdata", i_rdata, 0);
        chk("rmid_drdata", d_rdata, 0);
        chk("rmid_stall_n", stall_n, 0);
        chk_quiet("rmid");
        last_i     = '0;
        last_d     = '0;
        dcnt_m     = 0;
        i_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        chk_quiet("rmid_hold");
        rst_n = 1'b1;
        step();
        chk_quiet("rmid_late_rvalid");
        chk("rmid_late_req", mem_req, 0);
        mem_rvalid = 1'b0;
        i_req      = 1'b1;
        i_addr     = 32'h0000_0304;
        run_txn(1, 1, 1'b0, 1'b0, 32'hCAFE_0001, g);
        chk("rmid_after_grant_i", g, 1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom % 5 == 0) begin
                i_req   = 1'b0;
                d_read  = 1'b0;
                d_write = 1'b0;
                step();
                chk("idle_req", mem_req, 0);
                chk("idle_stall_n", stall_n, 1);
            end
            i_req   = 1'($urandom % 2);
            d_read  = 1'($urandom % 2);
            d_write = 1'($urandom % 2);
            if (!(i_req || d_read || d_write)) i_req = 1'b1;
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_mode  = 1'($urandom % 2);
            run_txn($urandom % 4, $urandom % 3, ($urandom % 6) == 0,
                    ($urandom % 3) == 0, $urandom, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
